// File: rtl/pipelined_cskip_adder_if.sv
// Operand/result handshake bundle for pipelined_cskip_adder.
//   master (upstream/downstream side): drives in_valid, x1, x2, cin, op_sub, out_ready
//   slave  (adder side):               drives in_ready, out_valid, s, cout, ovf
// WIDTH must match the WIDTH parameter of the adder it is bound to.
interface pipelined_cskip_adder_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] x1;
    logic [WIDTH-1:0] x2;
    logic             cin;
    logic             op_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, x1, x2, cin, op_sub, out_ready,
        input  in_ready, out_valid, s, cout, ovf
    );

    modport slave (
        input  in_valid, x1, x2, cin, op_sub, out_ready,
        output in_ready, out_valid, s, cout, ovf
    );
endinterface

// File: rtl/pipelined_cskip_adder.sv
// Pipelined carry-skip adder/subtractor, one BLOCK-bit carry-skip block per stage.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset, clears every stage valid and the outputs
//   bus    - slave modport of pipelined_cskip_adder_if:
//            in_valid/in_ready/x1/x2/cin/op_sub in, out_valid/out_ready/s/cout/ovf out
// Latency is NBLK accepting edges; in_ready is the only combinational output
// (follows out_ready). Whole pipeline stalls together when the result is held.
module pipelined_cskip_adder #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned BLOCK = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    pipelined_cskip_adder_if.slave  bus
);
    localparam int unsigned NBLK = WIDTH / BLOCK;

    if (BLOCK < 2 || (WIDTH % BLOCK) != 0) begin : g_param_check
        $error("pipelined_cskip_adder: WIDTH must be a multiple of BLOCK and BLOCK >= 2");
    end

    // Global advance: move everything unless a finished result is being held.
    logic en;
    assign en          = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = en;

    for (genvar i = 0; i < NBLK; i++) begin : g_stage
        localparam int unsigned IN_W  = WIDTH - i * BLOCK;   // operand bits not yet consumed
        localparam int unsigned SUM_W = (i + 1) * BLOCK;     // result bits known after this stage

        logic [IN_W-1:0]  a_in;
        logic [IN_W-1:0]  b_in;
        logic             c_in;
        logic             v_in;
        logic [BLOCK-1:0] a_blk;
        logic [BLOCK-1:0] b_blk;
        logic [BLOCK-1:0] p_blk;
        logic [BLOCK-1:0] s_blk;
        logic             co_rip;
        logic             co_skip;
        logic [SUM_W-1:0] sum_nx;

        logic             v_q;
        logic             c_q;
        logic [SUM_W-1:0] sum_q;

        // Stage inputs: stage 0 takes the bus (with subtract folded in), others the previous stage.
        if (i == 0) begin : g_head
            assign a_in   = bus.x1;
            assign b_in   = bus.x2 ^ {WIDTH{bus.op_sub}};
            assign c_in   = bus.cin ^ bus.op_sub;
            assign v_in   = bus.in_valid;
            assign sum_nx = s_blk;
        end else begin : g_body
            assign a_in   = g_stage[i-1].g_fwd.a_q;
            assign b_in   = g_stage[i-1].g_fwd.b_q;
            assign c_in   = g_stage[i-1].c_q;
            assign v_in   = g_stage[i-1].v_q;
            assign sum_nx = {s_blk, g_stage[i-1].sum_q};
        end

        // Block adder plus skip mux: an all-propagate block passes its carry-in straight through.
        assign a_blk             = a_in[BLOCK-1:0];
        assign b_blk             = b_in[BLOCK-1:0];
        assign p_blk             = a_blk ^ b_blk;
        assign {co_rip, s_blk}   = {1'b0, a_blk} + {1'b0, b_blk} + (BLOCK+1)'(c_in);
        assign co_skip           = (&p_blk) ? c_in : co_rip;

        // Stage register: valid, accumulated low sum, carry.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q   <= 1'b0;
                c_q   <= 1'b0;
                sum_q <= '0;
            end else if (en) begin
                v_q   <= v_in;
                c_q   <= co_skip;
                sum_q <= sum_nx;
            end
        end

        // Unconsumed upper operand bits travel with the beat.
        if (i < NBLK - 1) begin : g_fwd
            logic [IN_W-BLOCK-1:0] a_q;
            logic [IN_W-BLOCK-1:0] b_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (en) begin
                    a_q <= a_in[IN_W-1:BLOCK];
                    b_q <= b_in[IN_W-1:BLOCK];
                end
            end
        end

        // Last stage: overflow from the carry into the MSB, and the output drive.
        if (i == NBLK - 1) begin : g_tail
            logic c_msb;
            logic ovf_q;

            assign c_msb = s_blk[BLOCK-1] ^ a_blk[BLOCK-1] ^ b_blk[BLOCK-1];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_q <= 1'b0;
                end else if (en) begin
                    ovf_q <= c_msb ^ co_skip;
                end
            end

            assign bus.out_valid = v_q;
            assign bus.s         = sum_q;
            assign bus.cout      = c_q;
            assign bus.ovf       = ovf_q;
        end
    end
endmodule
